// File: rtl/vending_pkg.sv
// vending_pkg: coin codes, arbiter state encoding and coin legality helper
package vending_pkg;
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_GAP, S_ABORT} state_t;

    function automatic logic coin_legal(input logic [1:0] c);
        return (c == COIN_5) || (c == COIN_10);
    endfunction
endpackage

// File: rtl/vending_rr_picker.sv
// vending_rr_picker: first set request at or after ptr, wrapping, as one-hot and index
module vending_rr_picker #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);
    always_comb begin
        idx = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[IW'((int'(ptr) + k) % N)]) begin
                found = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
        grant = found ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/vending_session_arbiter.sv
// vending_session_arbiter: shares one vending core between N_REQ coin slots,
// one locked session at a time, with paced coin pulses and an idle-abort timer.
module vending_session_arbiter
    import vending_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int TIMEOUT = 16,
    parameter int CNT_W = 16,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [2*N_REQ-1:0]   req_coin,
    output logic [N_REQ-1:0]     req_ready,
    output logic [1:0]           vm_in,
    output logic                 vm_rst,
    input  logic                 vm_out,
    input  logic [1:0]           vm_change,
    output logic                 vend_valid,
    output logic [IW-1:0]        vend_id,
    output logic [1:0]           vend_change,
    output logic                 abort_valid,
    output logic [IW-1:0]        abort_id,
    output logic                 coin_err,
    output logic                 busy,
    output logic [CNT_W-1:0]     vend_count
);
    localparam int TW = $clog2(TIMEOUT);

    state_t            state_q, state_d;
    logic              lock_q, lock_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [1:0]        coin_q, coin_d;
    logic [1:0]        vm_in_q, vm_in_d;
    logic              vend_valid_q, vend_valid_d;
    logic [IW-1:0]     vend_id_q, vend_id_d;
    logic [1:0]        vend_change_q, vend_change_d;
    logic              abort_valid_q, abort_valid_d;
    logic [IW-1:0]     abort_id_q, abort_id_d;
    logic              coin_err_q, coin_err_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [N_REQ-1:0]  pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_found;
    logic              can_grant, granted;
    logic [1:0]        pick_coin;

    // While locked, only the owner's request is visible to the picker
    vending_rr_picker #(.N(N_REQ)) u_picker (
        .req   (lock_q ? (req_valid & (N_REQ'(1) << owner_q)) : req_valid),
        .ptr   (rr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign can_grant = (state_q == S_IDLE) && !rst;
    assign granted   = can_grant && pick_found;
    assign req_ready = can_grant ? pick_grant : '0;
    assign pick_coin = req_coin[{pick_idx, 1'b0} +: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lock_q        <= 1'b0;
            owner_q       <= '0;
            rr_q          <= '0;
            timer_q       <= '0;
            coin_q        <= COIN_NONE;
            vm_in_q       <= COIN_NONE;
            vend_valid_q  <= 1'b0;
            vend_id_q     <= '0;
            vend_change_q <= '0;
            abort_valid_q <= 1'b0;
            abort_id_q    <= '0;
            coin_err_q    <= 1'b0;
            busy_q        <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            lock_q        <= lock_d;
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            timer_q       <= timer_d;
            coin_q        <= coin_d;
            vm_in_q       <= vm_in_d;
            vend_valid_q  <= vend_valid_d;
            vend_id_q     <= vend_id_d;
            vend_change_q <= vend_change_d;
            abort_valid_q <= abort_valid_d;
            abort_id_q    <= abort_id_d;
            coin_err_q    <= coin_err_d;
            busy_q        <= busy_d;
            count_q       <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        timer_d = timer_q;
        coin_d  = coin_q;
        case (state_q)
            S_IDLE: begin
                // An owner grant on the expiry cycle beats the abort
                if (granted) begin
                    if (coin_legal(pick_coin)) begin
                        state_d = S_DRIVE;
                        owner_d = pick_idx;
                        coin_d  = pick_coin;
                        rr_d    = IW'((int'(pick_idx) + 1) % N_REQ);
                    end
                end else if (lock_q) begin
                    state_d = (timer_q == TW'(TIMEOUT - 1)) ? S_ABORT : S_IDLE;
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DRIVE:  state_d = S_SAMPLE;
            S_SAMPLE: begin
                lock_d  = !vm_out;
                timer_d = '0;
                state_d = S_GAP;
            end
            S_GAP:    state_d = S_IDLE;
            S_ABORT: begin
                lock_d  = 1'b0;
                timer_d = '0;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vm_in_d       = (state_d == S_DRIVE) ? coin_d : COIN_NONE;
        vend_valid_d  = (state_q == S_SAMPLE) && vm_out;
        vend_id_d     = vend_valid_d ? owner_q : vend_id_q;
        vend_change_d = vend_valid_d ? vm_change : vend_change_q;
        abort_valid_d = (state_d == S_ABORT);
        abort_id_d    = abort_valid_d ? owner_q : abort_id_q;
        coin_err_d    = granted && !coin_legal(pick_coin);
        busy_d        = lock_d || (state_d != S_IDLE);
        count_d       = count_q + CNT_W'(vend_valid_d);
    end

    assign vm_in       = vm_in_q;
    assign vm_rst      = rst || abort_valid_q;
    assign vend_valid  = vend_valid_q;
    assign vend_id     = vend_id_q;
    assign vend_change = vend_change_q;
    assign abort_valid = abort_valid_q;
    assign abort_id    = abort_id_q;
    assign coin_err    = coin_err_q;
    assign busy        = busy_q;
    assign vend_count  = count_q;
endmodule

// File: tb/tb_vending_session_arbiter.sv
// tb_vending_session_arbiter: random requesters against a transaction-level
// session model; expected events are queued and matched by a separate monitor.
module tb_vending_session_arbiter;
    localparam int N = 3;
    localparam int TO = 16;
    localparam int CW = 16;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [2*N-1:0] req_coin = '0;
    logic [N-1:0]   req_ready;
    logic [1:0]     vm_in, vend_change;
    logic [1:0]     vm_change = 2'b00;
    logic           vm_out = 1'b0;
    logic           vm_rst, vend_valid, abort_valid, coin_err, busy;
    logic [IW-1:0]  vend_id, abort_id;
    logic [CW-1:0]  vend_count;

    int checks = 0;
    int passed = 0;
    int n_vend = 0, n_abort = 0, n_err = 0;

    typedef struct {int kind; int id; int chg;} ev_t;  // kind 0 vend, 1 abort, 2 coin_err
    ev_t q[$];

    always #5 clk = ~clk;

    vending_session_arbiter #(.N_REQ(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_coin(req_coin),
        .req_ready(req_ready), .vm_in(vm_in), .vm_rst(vm_rst), .vm_out(vm_out),
        .vm_change(vm_change), .vend_valid(vend_valid), .vend_id(vend_id),
        .vend_change(vend_change), .abort_valid(abort_valid), .abort_id(abort_id),
        .coin_err(coin_err), .busy(busy), .vend_count(vend_count)
    );

    // Stand-in core: 15-cent machine, 20 returns a 5 change code, holds on 00
    int core_tot = 0;
    function automatic int coin_val(input logic [1:0] c);
        return (c == 2'b01) ? 5 : 10;
    endfunction
    always @(posedge clk) begin
        if (vm_rst) begin
            core_tot <= 0;
            vm_out <= 1'b0;
            vm_change <= 2'b00;
        end else if (vm_in != 2'b00) begin
            vm_out <= (core_tot + coin_val(vm_in)) >= 15;
            vm_change <= (core_tot + coin_val(vm_in) == 20) ? 2'b01 : 2'b00;
            core_tot <= ((core_tot + coin_val(vm_in)) >= 15) ? 0 : core_tot + coin_val(vm_in);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops one expected event per observed pulse
    int exp_cnt = 0;
    initial forever begin
        ev_t e;
        @(negedge clk);
        #2;
        if (rst) exp_cnt = 0;
        else if (vend_valid || abort_valid || coin_err) begin
            if (q.size() == 0) check("unexpected event", {vend_valid, abort_valid, coin_err}, 0);
            else begin
                e = q.pop_front();
                check("event kind", {vend_valid, abort_valid, coin_err}, 3'b100 >> e.kind);
                if (e.kind == 0) begin
                    n_vend++;
                    exp_cnt++;
                    check("vend_id", vend_id, e.id);
                    check("vend_change", vend_change, e.chg);
                    check("vend_count", vend_count, exp_cnt);
                end else if (e.kind == 1) begin
                    n_abort++;
                    check("abort_id", abort_id, e.id);
                end else n_err++;
            end
        end
    end

    initial begin
        int sleep[N];
        int tot[N];
        logic hs[N];
        int ph, lock, own, rr, tmr, g, r;
        logic [1:0] code, c;
        logic [N-1:0] exp_rdy;
        logic rst_done;
        ph = 0; lock = 0; own = 0; rr = 0; tmr = 0; code = 2'b00; rst_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            sleep[i] = $urandom_range(0, 3);
            tot[i] = 0;
            hs[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        check("reset vm_rst", vm_rst, 1);
        check("reset vm_in", vm_in, 0);
        check("reset busy", busy, 0);
        check("reset pulses", {vend_valid, abort_valid, coin_err}, 0);
        check("reset vend_count", vend_count, 0);
        check("reset ids", {vend_id, abort_id, vend_change}, 0);
        rst = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            // One mid-run reset landing on a DRIVE cycle
            rst = (cyc >= 4000) && !rst_done && (ph == 1);
            if (rst) rst_done = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    req_valid[i] = 1'b0;
                    hs[i] = 1'b0;
                    r = $urandom_range(0, 7);
                    sleep[i] = (r < 4) ? $urandom_range(0, 3) : (r < 6) ? $urandom_range(13, 20) : $urandom_range(25, 40);
                end else if (!req_valid[i]) begin
                    if (sleep[i] > 0) sleep[i]--;
                    else if (cyc < 5800) begin
                        r = $urandom_range(0, 19);
                        req_valid[i] = 1'b1;
                        req_coin[2*i +: 2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 11) ? 2'b01 : 2'b10;
                    end
                end
            end
            #1;
            g = -1;
            exp_rdy = '0;
            if (!rst && ph == 0) begin
                if (lock != 0) g = req_valid[own] ? own : -1;
                else for (int k = 0; k < N; k++) if (g < 0 && req_valid[(rr + k) % N]) g = (rr + k) % N;
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            check("req_ready", req_ready, exp_rdy);
            check("vm_in", vm_in, (ph == 1) ? code : 2'b00);
            check("vm_rst", vm_rst, rst || ph == 4);
            check("busy", busy, ph != 0 || lock != 0);
            if (rst) begin
                ph = 0; lock = 0; rr = 0; tmr = 0;
                for (int i = 0; i < N; i++) tot[i] = 0;
                q.delete();
            end else if (ph == 1) ph = 2;
            else if (ph == 2) ph = 3;
            else if (ph >= 3) ph = 0;
            else if (g >= 0) begin
                c = req_coin[2*g +: 2];
                hs[g] = 1'b1;
                if (c == 2'b00 || c == 2'b11) q.push_back('{2, g, 0});
                else begin
                    tot[g] += (c == 2'b01) ? 5 : 10;
                    rr = (g + 1) % N;
                    code = c;
                    ph = 1;
                    tmr = 0;
                    if (tot[g] >= 15) begin
                        q.push_back('{0, g, (tot[g] == 20) ? 1 : 0});
                        tot[g] = 0;
                        lock = 0;
                    end else begin
                        lock = 1;
                        own = g;
                    end
                end
            end else if (lock != 0) begin
                if (tmr == TO - 1) begin
                    q.push_back('{1, own, 0});
                    ph = 4; lock = 0; tot[own] = 0; tmr = 0;
                end else tmr++;
            end
        end
        repeat (3) @(negedge clk);
        check("events drained", q.size(), 0);
        check("mid-run reset applied", rst_done, 1);
        check("vends seen", n_vend > 0, 1);
        check("aborts seen", n_abort > 0, 1);
        check("coin errors seen", n_err > 0, 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
